axis_rx_frame_filter: RTL and testbench
=======================================

AXIS_RX_FRAME_FILTER -- requirements
Module: axis_rx_frame_filter

Interface
REQ-001 Parameters SHALL be: AXIS_TDATA_WIDTH, default 512, beat data width; AXIS_TKEEP_WIDTH, default 64, byte-enable width; DEPTH_LOG2, default 6, log2 of buffer depth in beats; MAX_FRAME_BEATS, default 24, largest accepted frame in beats (must be < 2^DEPTH_LOG2).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 s_axi_stream_tvalid  in  1  MAC-side beat valid.
REQ-006 s_axi_stream_tready  out  1  beat accepted when tvalid & tready.
REQ-007 s_axi_stream_tdata  in  AXIS_TDATA_WIDTH  beat data.
REQ-008 s_axi_stream_tkeep  in  AXIS_TKEEP_WIDTH  byte enables.
REQ-009 s_axi_stream_tlast  in  1  last beat of frame.
REQ-010 s_axi_stream_tuser  in  1  frame error flag; sampled on the tlast beat only.
REQ-011 m_axi_stream_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/AXIS_TDATA_WIDTH/AXIS_TKEEP_WIDTH/1/1  filtered stream to the UDP/ARP Rx input.
REQ-012 frame_pass_count  out  32  frames committed since reset.
REQ-013 frame_drop_count  out  32  frames discarded since reset.

Function
REQ-014 The block SHALL be store-and-forward: no beat of a frame appears on m_axi_stream until its tlast beat has been accepted and the frame committed.
REQ-015 Buffer SHALL hold 2^DEPTH_LOG2 entries of {tdata, tkeep, tlast}; pointers wr_ptr, commit_ptr and rd_ptr SHALL each be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
REQ-016 full = (wr_ptr - rd_ptr == 2^DEPTH_LOG2); m_axi_stream_tvalid = (rd_ptr != commit_ptr).
REQ-017 The write FSM SHALL have states IDLE (between frames), RECV (mid-frame) and DROP (discarding the tail of an oversize frame).
REQ-018 In IDLE/RECV: s_axi_stream_tready = !full; in DROP: s_axi_stream_tready = 1.
REQ-019 Accepted beat in IDLE/RECV SHALL be written at wr_ptr, wr_ptr += 1, and the frame beat counter += 1. IDLE goes to RECV on a non-last beat.
REQ-020 Accepted tlast beat with tuser=0 and beat count <= MAX_FRAME_BEATS: commit_ptr <= wr_ptr+1, frame_pass_count += 1, next state IDLE.
REQ-021 Accepted tlast beat with tuser=1: wr_ptr <= commit_ptr (rewind), frame_drop_count += 1, next state IDLE, nothing emitted.
REQ-022 Accepted non-last beat that is beat number MAX_FRAME_BEATS+1: wr_ptr <= commit_ptr, frame_drop_count += 1, next state DROP.
REQ-023 In DROP, beats SHALL be discarded without writing; on the tlast beat the FSM returns to IDLE with no further counter change.
REQ-024 A single-beat frame (tlast on first beat) SHALL follow REQ-020/021 directly from IDLE.
REQ-025 Read side: m_axi_stream_tdata/tkeep/tlast SHALL come from the entry at rd_ptr; rd_ptr += 1 on m_axi_stream_tvalid & m_axi_stream_tready; m_axi_stream_tuser SHALL be constant 0.
REQ-026 Latency: m_axi_stream_tvalid SHALL assert in the cycle after the committing tlast handshake, provided the buffer was empty.
REQ-027 Simultaneous write, commit and read in one cycle SHALL all take effect. full is evaluated on pre-update pointers. A read SHALL never pass commit_ptr.
REQ-028 Output data SHALL remain stable while m_axi_stream_tvalid=1 and m_axi_stream_tready=0.
REQ-029 Counters SHALL wrap modulo 2^32.

Reset
REQ-030 While reset=1, on each clock edge: all pointers, the beat counter and both counters <= 0; FSM <= IDLE. Every partial or uncommitted frame is lost.
REQ-031 During and after reset: m_axi_stream_tvalid = 0, s_axi_stream_tready = 1. m_axi_stream_tdata, tkeep and tlast are don't-care while tvalid = 0.
REQ-032 After reset deassertion, the first accepted beat SHALL be treated as a frame start.

Verification
REQ-033 Good 3-beat frame, tuser=0, m_tready=1 -> identical 3 beats out, first in the cycle after input tlast; pass_count=1, drop_count=0.
REQ-034 4-beat frame with tuser=1 on tlast, then a good 2-beat frame -> only the 2-beat frame out; drop_count=1, pass_count=1.
REQ-035 30-beat frame, MAX_FRAME_BEATS=24 -> tready stays 1 through beat 30; nothing out; drop_count=1. A following 1-beat frame passes.
REQ-036 m_tready=0, three 24-beat good frames (72 > 64 entries) -> tready drops when full. Releasing m_tready drains all 72 beats in order; pass_count=3.
REQ-037 reset pulsed after beat 2 of a 5-beat frame -> no output, counters 0. A new 2-beat frame after reset passes unchanged.
REQ-038 Random back-pressure on both sides with mixed good, error and oversize frames -> output equals a scoreboard of good frames only, beat-exact; counters match.

Source files
------------

// File: rtl/axis_rx_frame_filter.sv
// Store-and-forward AXI-Stream frame filter: buffers each frame and forwards it only
// when it ends cleanly (tuser=0 on tlast) within MAX_FRAME_BEATS; others are discarded.
module axis_rx_frame_filter #(
    parameter int AXIS_TDATA_WIDTH = 512,
    parameter int AXIS_TKEEP_WIDTH = 64,
    parameter int DEPTH_LOG2       = 6,
    parameter int MAX_FRAME_BEATS  = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_axi_stream_tvalid,
    output logic                        s_axi_stream_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axi_stream_tdata,
    input  logic [AXIS_TKEEP_WIDTH-1:0] s_axi_stream_tkeep,
    input  logic                        s_axi_stream_tlast,
    input  logic                        s_axi_stream_tuser,
    output logic                        m_axi_stream_tvalid,
    input  logic                        m_axi_stream_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axi_stream_tdata,
    output logic [AXIS_TKEEP_WIDTH-1:0] m_axi_stream_tkeep,
    output logic                        m_axi_stream_tlast,
    output logic                        m_axi_stream_tuser,
    output logic [31:0]                 frame_pass_count,
    output logic [31:0]                 frame_drop_count
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int PTR_W   = DEPTH_LOG2 + 1;
    localparam int ENTRY_W = AXIS_TDATA_WIDTH + AXIS_TKEEP_WIDTH + 1;
    localparam int CNT_W   = $clog2(MAX_FRAME_BEATS + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_commit_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [31:0]        r_pass_count;
    logic [31:0]        r_drop_count;

    logic               w_full;
    logic               w_s_tready;
    logic               w_m_tvalid;
    logic               w_accept;
    logic               w_rd;
    logic               w_wr_en;
    logic               w_commit;
    logic               w_rewind;
    logic               w_pass_inc;
    logic               w_drop_inc;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic [ENTRY_W-1:0] w_rd_entry;

    assign w_full     = ((r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH));
    assign w_m_tvalid = !reset && (r_rd_ptr != r_commit_ptr);
    assign w_accept   = s_axi_stream_tvalid && w_s_tready;
    assign w_rd       = w_m_tvalid && m_axi_stream_tready;
    assign w_rd_entry = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    assign s_axi_stream_tready = w_s_tready;
    assign m_axi_stream_tvalid = w_m_tvalid;
    assign m_axi_stream_tdata  = w_rd_entry[AXIS_TDATA_WIDTH-1:0];
    assign m_axi_stream_tkeep  = w_rd_entry[AXIS_TDATA_WIDTH +: AXIS_TKEEP_WIDTH];
    assign m_axi_stream_tlast  = w_rd_entry[ENTRY_W-1];
    assign m_axi_stream_tuser  = 1'b0;
    assign frame_pass_count    = r_pass_count;
    assign frame_drop_count    = r_drop_count;

    // Input ready: DROP swallows beats unconditionally, otherwise wait for space.
    always_comb begin
        w_s_tready = 1'b1;
        if (reset) begin
            w_s_tready = 1'b1;
        end else if (r_state == ST_DROP) begin
            w_s_tready = 1'b1;
        end else begin
            w_s_tready = !w_full;
        end
    end

    // Write FSM next-state and datapath control.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_rewind     = 1'b0;
        w_pass_inc   = 1'b0;
        w_drop_inc   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE, ST_RECV: begin
                if (w_accept) begin
                    if (s_axi_stream_tlast) begin
                        // r_beat_cnt counts earlier beats, so this is beat r_beat_cnt+1
                        if (!s_axi_stream_tuser && (r_beat_cnt < CNT_W'(MAX_FRAME_BEATS))) begin
                            w_wr_en    = 1'b1;
                            w_commit   = 1'b1;
                            w_pass_inc = 1'b1;
                        end else begin
                            w_rewind   = 1'b1;
                            w_drop_inc = 1'b1;
                        end
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else if (r_beat_cnt == CNT_W'(MAX_FRAME_BEATS)) begin
                        w_rewind     = 1'b1;
                        w_drop_inc   = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_DROP;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_cnt_inc    = 1'b1;
                        w_next_state = ST_RECV;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_DROP: begin
                if (w_accept && s_axi_stream_tlast) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DROP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame buffer storage; contents are don't-care until committed, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {s_axi_stream_tlast, s_axi_stream_tkeep, s_axi_stream_tdata};
        end
    end

    // Pointers, per-frame beat counter and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_pass_count <= 32'd0;
            r_drop_count <= 32'd0;
        end else begin
            if (w_rewind) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_cnt_clr) begin
                r_beat_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_pass_inc) begin
                r_pass_count <= r_pass_count + 32'd1;
            end
            if (w_drop_inc) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_frame_filter.sv
// Scoreboard bench for axis_rx_frame_filter: good frames are queued as they are sent
// and compared beat-by-beat against the filtered output.
module tb_axis_rx_frame_filter;

    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int DL2  = 6;
    localparam int MAXB = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tuser;
    logic [31:0]   pass_cnt;
    logic [31:0]   drop_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_pass = 0;
    int            exp_drop = 0;
    int            bp_mode  = 0;
    bit            sf_mode  = 1'b0;
    logic [DW+KW:0] exp_q[$];
    logic [DW+KW:0] mon_e;
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic [KW-1:0] held_k = '0;

    axis_rx_frame_filter #(
        .AXIS_TDATA_WIDTH(DW),
        .AXIS_TKEEP_WIDTH(KW),
        .DEPTH_LOG2(DL2),
        .MAX_FRAME_BEATS(MAXB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axi_stream_tvalid(s_tvalid),
        .s_axi_stream_tready(s_tready),
        .s_axi_stream_tdata(s_tdata),
        .s_axi_stream_tkeep(s_tkeep),
        .s_axi_stream_tlast(s_tlast),
        .s_axi_stream_tuser(s_tuser),
        .m_axi_stream_tvalid(m_tvalid),
        .m_axi_stream_tready(m_tready),
        .m_axi_stream_tdata(m_tdata),
        .m_axi_stream_tkeep(m_tkeep),
        .m_axi_stream_tlast(m_tlast),
        .m_axi_stream_tuser(m_tuser),
        .frame_pass_count(pass_cnt),
        .frame_drop_count(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-side back-pressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                default: m_tready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Output monitor: scoreboard compare plus hold-stability under back-pressure.
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check_eq("hold_valid", m_tvalid, 1);
                check_eq("hold_data", m_tdata, held_d);
                check_eq("hold_keep", m_tkeep, held_k);
            end
            held_v = m_tvalid && !m_tready;
            held_d = m_tdata;
            held_k = m_tkeep;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("tdata", m_tdata, mon_e[DW-1:0]);
                    check_eq("tkeep", m_tkeep, mon_e[DW+KW-1:DW]);
                    check_eq("tlast", m_tlast, mon_e[DW+KW]);
                    check_eq("tuser", m_tuser, 0);
                end
            end
        end
    end

    // Sends one frame (or its first abort_after beats); entry/exit at posedge+1.
    task automatic send_frame(input int n_beats, input bit err, input int abort_after, input bit gaps);
        logic [DW+KW:0] beats[$];
        bit good;
        int n_sent;
        int t;
        bit first;
        good   = !err && (n_beats <= MAXB);
        n_sent = (abort_after > 0) ? abort_after : n_beats;
        for (int i = 0; i < n_sent; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_tdata  = {$urandom, $urandom};
            s_tlast  = (i == n_beats - 1);
            s_tkeep  = s_tlast ? KW'($urandom_range(1, 255)) : 8'hFF;
            s_tuser  = s_tlast ? err : 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            first    = 1'b1;
            t        = 0;
            forever begin
                @(negedge clk);
                if (first && (i >= MAXB + 1)) check_eq("drop_tready", s_tready, 1);
                if (sf_mode) check_eq("store_fwd", m_tvalid, 0);
                first = 1'b0;
                if (s_tready) break;
                t++;
                if (t > 3000) begin
                    check_eq("accept_timeout", t, 0);
                    s_tvalid = 1'b0;
                    return;
                end
            end
            beats.push_back({s_tlast, s_tkeep, s_tdata});
            if (s_tlast) begin
                if (good) begin
                    foreach (beats[j]) exp_q.push_back(beats[j]);
                    exp_pass++;
                end else begin
                    exp_drop++;
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_idle_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        check_eq({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit saw_full;
        int t;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_s_tready", s_tready, 1);
        check_eq("rst_pass", pass_cnt, 0);
        check_eq("rst_drop", drop_cnt, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_tready", s_tready, 1);

        // Good 3-beat frame: nothing out until tlast, then valid the next cycle.
        sf_mode = 1'b1;
        send_frame(3, 1'b0, 0, 1'b0);
        sf_mode = 1'b0;
        check_eq("latency_tvalid", m_tvalid, 1);
        drain_and_check("t1");

        // Errored 4-beat frame then a good 2-beat frame.
        send_frame(4, 1'b1, 0, 1'b0);
        send_frame(2, 1'b0, 0, 1'b0);
        drain_and_check("t2");

        // Oversize 30-beat frame then a single-beat frame.
        send_frame(30, 1'b0, 0, 1'b0);
        send_frame(1, 1'b0, 0, 1'b0);
        drain_and_check("t3");

        // Three 24-beat frames against a stalled output overflow the 64-entry buffer.
        bp_mode = 1;
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) send_frame(24, 1'b0, 0, 1'b0);
            end
            begin
                saw_full = 1'b0;
                t = 0;
                while (!saw_full && t < 2000) begin
                    @(negedge clk);
                    if (!s_tready) saw_full = 1'b1;
                    t++;
                end
                check_eq("full_seen", saw_full, 1);
                check_eq("full_no_output", m_tvalid && m_tready, 0);
                repeat (4) @(posedge clk);
                bp_mode = 0;
            end
        join
        drain_and_check("t4");

        // Reset in the middle of a frame discards it and clears the counters.
        send_frame(5, 1'b0, 2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_tready", s_tready, 1);
        check_eq("midrst_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1;
        check_eq("midrst_pass", pass_cnt, 0);
        check_eq("midrst_drop", drop_cnt, 0);
        exp_pass = 0;
        exp_drop = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(2, 1'b0, 0, 1'b0);
        drain_and_check("t5");

        // Mixed random traffic with back-pressure on both sides.
        bp_mode = 2;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 30), ($urandom_range(0, 4) == 0), 0, 1'b1);
        end
        drain_and_check("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
